// File: rtl/forward_pkg.sv
// forward_pkg: shared scoreboard entry type, bypass-select constants and the
// select-width helper used by the forwarding/hazard unit and its interface.
package forward_pkg;

  // Storage width of the entry fields. Module parameters REG_AW and LAT_W
  // are expected to be no wider than these.
  localparam int FWD_RD_W  = 5;
  localparam int FWD_LAT_W = 2;

  // Bypass select value meaning "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  // One in-flight register writer held in a post-EX pipeline latch.
  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [FWD_RD_W-1:0]  rd;
    logic [FWD_LAT_W-1:0] lat;
  } fwd_entry_t;

  // Select values 0..stages (register file plus one per tracked entry).
  function automatic int fwd_sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// forward_scoreboard_if: issue/source/result bundle between the pipeline
// control (master) and the forwarding scoreboard (slave).
interface forward_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int STAGES  = 3,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 2
);
  localparam int SEL_W = forward_pkg::fwd_sel_width(STAGES);

  logic                       advance;
  logic                       flush;
  logic                       issue_valid;
  logic                       issue_we;
  logic [REG_AW-1:0]          issue_rd;
  logic [LAT_W-1:0]           issue_lat;
  logic [NUM_SRC*REG_AW-1:0]  src_reg;
  logic [NUM_SRC-1:0]         src_used;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic [7:0]                 stall_run;
  logic [31:0]                fwd_count;
  logic [31:0]                stall_count;

  modport master (
    output advance, flush, issue_valid, issue_we, issue_rd, issue_lat,
           src_reg, src_used,
    input  fwd_sel, stall, stall_run, fwd_count, stall_count
  );

  modport slave (
    input  advance, flush, issue_valid, issue_we, issue_rd, issue_lat,
           src_reg, src_used,
    output fwd_sel, stall, stall_run, fwd_count, stall_count
  );

endinterface

// File: rtl/fwd_match.sv
// fwd_match: compares one source operand against every scoreboard entry and
// returns the bypass select of the youngest matching writer, or a hazard
// when that writer's result is not yet available at its current entry.
module fwd_match
  import forward_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int SEL_W  = fwd_sel_width(STAGES)
) (
  input  fwd_entry_t [STAGES-1:0] entries,
  input  logic [REG_AW-1:0]       src_reg,
  input  logic                    src_used,
  output logic [SEL_W-1:0]        sel,
  output logic                    hazard
);

  logic [STAGES-1:0] hit;

  // Per-entry match: live writer of the same non-$zero register, source read.
  always_comb begin
    hit = '0;
    for (int i = 0; i < STAGES; i++) begin
      hit[i] = entries[i].valid && entries[i].we && src_used
               && (entries[i].rd == FWD_RD_W'(src_reg))
               && (entries[i].rd != '0);
    end
  end

  // Walk oldest to youngest so the youngest hit overwrites; a not-ready
  // youngest hit yields a hazard and never falls through to an older one.
  always_comb begin
    sel    = SEL_W'(FWD_SEL_RF);
    hazard = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        if (i >= int'(entries[i].lat)) begin
          sel    = SEL_W'(i + 1);
          hazard = 1'b0;
        end else begin
          sel    = SEL_W'(FWD_SEL_RF);
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: forwarding and load-use hazard unit for the in-order
// MIPS pipeline. Entry 0 is the EX/MEM latch, entry STAGES-1 the oldest.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module forward_scoreboard
  import forward_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int STAGES  = 3,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 2
) (
  input logic                 CLK,
  input logic                 RST,
  forward_scoreboard_if.slave sb
);

  localparam int SEL_W = fwd_sel_width(STAGES);

  fwd_entry_t [STAGES-1:0] entries;
  fwd_entry_t              issue_entry;
  logic [SEL_W-1:0]        src_sel [NUM_SRC];
  logic [NUM_SRC-1:0]      src_hazard;
  logic                    stall;
  logic [7:0]              stall_run_q;

  // One matcher per source operand, all looking at the same entries.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .REG_AW (REG_AW),
      .STAGES (STAGES),
      .SEL_W  (SEL_W)
    ) u_match (
      .entries  (entries),
      .src_reg  (sb.src_reg[s*REG_AW +: REG_AW]),
      .src_used (sb.src_used[s]),
      .sel      (src_sel[s]),
      .hazard   (src_hazard[s])
    );
  end

  // A redirect squashes the ID/EX instruction, so its hazards are moot.
  always_comb begin
    stall    = (|src_hazard) && !sb.flush;
    sb.stall = stall;
  end

  // Pack the per-source selects onto the flat output bus.
  always_comb begin
    sb.fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sb.fwd_sel[s*SEL_W +: SEL_W] = src_sel[s];
    end
  end

  // Entry presented to latch 0: the issuing writer, or a bubble when it is
  // absent, stalled or squashed.
  always_comb begin
    issue_entry = '0;
    if (sb.issue_valid && !stall && !sb.flush) begin
      issue_entry.valid = 1'b1;
      issue_entry.we    = sb.issue_we;
      issue_entry.rd    = FWD_RD_W'(sb.issue_rd);
      issue_entry.lat   = FWD_LAT_W'(sb.issue_lat);
    end
  end

  // Scoreboard shift register; moves only when the pipeline latches do.
  always_ff @(posedge CLK) begin
    if (RST) begin
      entries <= '0;
    end else if (sb.advance) begin
      for (int i = 1; i < STAGES; i++) begin
        entries[i] <= entries[i-1];
      end
      entries[0] <= issue_entry;
    end
  end

  // Length of the current stall, saturating; frozen while not advancing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_run_q <= 8'd0;
    end else if (sb.advance) begin
      if (stall) begin
        if (stall_run_q != 8'hFF) begin
          stall_run_q <= stall_run_q + 8'd1;
        end
      end else begin
        stall_run_q <= 8'd0;
      end
    end
  end

  assign sb.stall_run = stall_run_q;

`ifdef FWD_STATS_EN
  logic [31:0] fwd_count_q;
  logic [31:0] stall_count_q;
  logic [31:0] fwd_taken;

  // Number of sources bypassed from an entry this cycle.
  always_comb begin
    fwd_taken = 32'd0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_sel[s] != SEL_W'(FWD_SEL_RF)) begin
        fwd_taken = fwd_taken + 32'd1;
      end
    end
  end

  // Wrapping event counters for forwards taken and stall cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_count_q   <= 32'd0;
      stall_count_q <= 32'd0;
    end else if (sb.advance) begin
      if (stall) begin
        stall_count_q <= stall_count_q + 32'd1;
      end else begin
        fwd_count_q <= fwd_count_q + fwd_taken;
      end
    end
  end

  assign sb.fwd_count   = fwd_count_q;
  assign sb.stall_count = stall_count_q;
`else
  assign sb.fwd_count   = 32'd0;
  assign sb.stall_count = 32'd0;
`endif

  // A producer latency of STAGES or more could never be forwarded.
  a_lat_legal: assert property (@(posedge CLK) disable iff (RST)
    (sb.issue_valid && sb.issue_we) |-> (int'(sb.issue_lat) < STAGES));

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb_forward_scoreboard: directed vectors for the forwarding scoreboard.
// Expected counter values depend on whether FWD_STATS_EN is defined.
module tb_forward_scoreboard;

  localparam int REG_AW  = 5;
  localparam int STAGES  = 3;
  localparam int NUM_SRC = 2;
  localparam int LAT_W   = 2;

`ifdef FWD_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   error_count = 0;

  forward_scoreboard_if #(
    .REG_AW (REG_AW), .STAGES (STAGES), .NUM_SRC (NUM_SRC), .LAT_W (LAT_W)
  ) sb_if ();

  forward_scoreboard #(
    .REG_AW (REG_AW), .STAGES (STAGES), .NUM_SRC (NUM_SRC), .LAT_W (LAT_W)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one set of inputs and let the combinational outputs settle.
  task automatic applyStimulus(input int adv, input int fl, input int iv,
                               input int iwe, input int ird, input int ilat,
                               input int s0, input int s1, input int used);
    sb_if.advance     = 1'(adv);
    sb_if.flush       = 1'(fl);
    sb_if.issue_valid = 1'(iv);
    sb_if.issue_we    = 1'(iwe);
    sb_if.issue_rd    = 5'(ird);
    sb_if.issue_lat   = 2'(ilat);
    sb_if.src_reg     = {5'(s1), 5'(s0)};
    sb_if.src_used    = 2'(used);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic checkCore(input string tag, input int sel, input int stl);
    checkOutput({tag, "_sel"},   32'(sb_if.fwd_sel), 32'(sel));
    checkOutput({tag, "_stall"}, 32'(sb_if.stall),   32'(stl));
  endtask

  function automatic logic [31:0] statsExp(input int n);
    return STATS_ON ? 32'(n) : 32'd0;
  endfunction

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkCore("in_reset", 0, 0);
    checkOutput("in_reset_run", 32'(sb_if.stall_run), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCore("post_reset", 0, 0);
    checkOutput("post_reset_fcnt", sb_if.fwd_count, 32'd0);
    checkOutput("post_reset_scnt", sb_if.stall_count, 32'd0);

    // ALU chain and two sources from different entries
    applyStimulus(1, 0, 1, 1, 8, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 1, 10, 0, 8, 3, 3);
    checkCore("alu_e0", 1, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 8, 10, 3);
    checkCore("two_src", 6, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 8, 0, 1);
    checkCore("alu_e2", 3, 0);
    tick();
    checkOutput("alu_fcnt", sb_if.fwd_count, statsExp(4));
    checkOutput("alu_scnt", sb_if.stall_count, statsExp(0));

    // Load-use: one advancing stall, bubble in entry 0, then forward from entry 1
    doReset();
    applyStimulus(1, 0, 1, 1, 9, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 1, 11, 0, 11, 9, 3);
    checkCore("ld_use", 0, 1);
    tick();
    checkOutput("ld_use_run1", 32'(sb_if.stall_run), 32'd1);
    checkCore("ld_resolved", 8, 0);
    tick();
    checkOutput("ld_use_run0", 32'(sb_if.stall_run), 32'd0);
    checkOutput("ld_fcnt", sb_if.fwd_count, statsExp(1));
    checkOutput("ld_scnt", sb_if.stall_count, statsExp(1));

    // Latency-2 producer: two advancing stall cycles
    doReset();
    applyStimulus(1, 0, 1, 1, 5, 2, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 1, 6, 0, 5, 0, 1);
    checkCore("lat2_e0", 0, 1);
    tick();
    checkCore("lat2_e1", 0, 1);
    checkOutput("lat2_run1", 32'(sb_if.stall_run), 32'd1);
    tick();
    checkCore("lat2_e2", 3, 0);
    checkOutput("lat2_run2", 32'(sb_if.stall_run), 32'd2);
    tick();
    checkOutput("lat2_run0", 32'(sb_if.stall_run), 32'd0);
    checkOutput("lat2_scnt", sb_if.stall_count, statsExp(2));
    checkOutput("lat2_fcnt", sb_if.fwd_count, statsExp(1));

    // Youngest match wins; a not-ready youngest stalls instead of using older
    doReset();
    applyStimulus(1, 0, 1, 1, 4, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0, 1);
    checkCore("young_ready", 1, 0);
    doReset();
    applyStimulus(1, 0, 1, 1, 4, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 1, 4, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0, 1);
    checkCore("young_load", 0, 1);

    // $zero writer and unused source never forward or stall
    doReset();
    applyStimulus(1, 0, 1, 1, 7, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 1);
    checkCore("zero_unused", 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 3);
    checkCore("src1_used", 8, 0);

    // Flush during a load-use hazard cancels the stall and inserts a bubble
    doReset();
    applyStimulus(1, 0, 1, 1, 9, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 1, 12, 0, 0, 9, 2);
    checkCore("flush_haz", 0, 0);
    tick();
    checkOutput("flush_run", 32'(sb_if.stall_run), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 12, 9, 3);
    checkCore("flush_bubble", 8, 0);

    // Hazard with advance low: frozen for three cycles, then reset mid-stall
    doReset();
    applyStimulus(1, 0, 1, 1, 9, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 1, 13, 0, 0, 9, 2);
    checkCore("hold_start", 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkCore("hold", 0, 1);
      checkOutput("hold_run", 32'(sb_if.stall_run), 32'd0);
    end
    checkOutput("hold_scnt", sb_if.stall_count, 32'd0);
    rst = 1'b1;
    tick();
    checkCore("rst_stall", 0, 0);
    rst = 1'b0;
    #1;
    checkCore("after_rst", 0, 0);
    checkOutput("after_rst_run", 32'(sb_if.stall_run), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
